countdown_timer: RTL and testbench

//  Synchronous loadable down-counter/timer; the counting-down counterpart of the team's 6-bit ripple up-counter.

---
 rtl/countdown_timer_pkg.sv | 12 +
 rtl/countdown_timer_if.sv | 26 ++
 rtl/down_count_reg.sv | 41 ++++
 rtl/countdown_timer.sv | 115 +++++++++++
 tb/tb_countdown_timer.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/countdown_timer_pkg.sv
// rtl/countdown_timer_pkg.sv - shared state encodings and default width for the countdown timer
package countdown_timer_pkg;

   localparam int CT_WIDTH = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } ct_state_e;

endpackage

// File: rtl/countdown_timer_if.sv
// rtl/countdown_timer_if.sv - control/status bundle of the countdown timer
interface countdown_timer_if
   import countdown_timer_pkg::*;
#(
   parameter int WIDTH = CT_WIDTH
);
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             start;
   logic             stop;
   logic             auto_reload;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             busy;
   logic             done;

   modport master (
      output load, load_val, start, stop, auto_reload,
      input  count, tc, busy, done
   );

   modport slave (
      input  load, load_val, start, stop, auto_reload,
      output count, tc, busy, done
   );
endinterface

// File: rtl/down_count_reg.sv
// rtl/down_count_reg.sv - loadable down-count register with terminal (==1) flag
module down_count_reg
   import countdown_timer_pkg::*;
#(
   parameter int WIDTH = CT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_en_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             dec_en_i,
   output logic [WIDTH-1:0] count_o,
   output logic             is_one_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // next count: load beats decrement; decrement never wraps below zero
   always_comb begin
      count_d = count_q;
      if (load_en_i) begin
         count_d = load_val_i;
      end else if (dec_en_i && (count_q != '0)) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   // count register, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o  = count_q;
   assign is_one_o = (count_q == WIDTH'(1));

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - one-shot/periodic loadable down-counter with terminal-count pulse
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int WIDTH = CT_WIDTH
) (
   input  logic              clk,
   input  logic              rst_n,
   countdown_timer_if.slave  bus
);

   ct_state_e        state_q, state_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             tc_q, tc_d;
   logic             busy_q, done_q;

   logic             cnt_load;
   logic [WIDTH-1:0] cnt_load_val;
   logic             cnt_dec;
   logic [WIDTH-1:0] cnt;
   logic             cnt_is_one;
   logic [WIDTH-1:0] start_val;

   down_count_reg #(.WIDTH(WIDTH)) u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_en_i  (cnt_load),
      .load_val_i (cnt_load_val),
      .dec_en_i   (cnt_dec),
      .count_o    (cnt),
      .is_one_o   (cnt_is_one)
   );

   // value a start would launch with: fresh load, else resume, else reload value
   always_comb begin
      if (bus.load) begin
         start_val = bus.load_val;
      end else if (cnt != '0) begin
         start_val = cnt;
      end else begin
         start_val = reload_q;
      end
   end

   // next state, counter controls and terminal pulse; stop > load > start > decrement
   always_comb begin
      state_d      = state_q;
      reload_d     = reload_q;
      tc_d         = 1'b0;
      cnt_load     = 1'b0;
      cnt_load_val = bus.load_val;
      cnt_dec      = 1'b0;
      case (state_q)
         ST_RUN: begin
            // a load while running only retargets the next period
            if (bus.load) begin
               reload_d = bus.load_val;
            end
            if (bus.stop) begin
               state_d = ST_IDLE;
            end else if (cnt_is_one) begin
               tc_d     = 1'b1;
               cnt_load = 1'b1;
               if (bus.auto_reload && (reload_q != '0)) begin
                  cnt_load_val = reload_q;
               end else begin
                  cnt_load_val = '0;
                  state_d      = ST_DONE;
               end
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: begin
            if (bus.load) begin
               reload_d = bus.load_val;
               cnt_load = 1'b1;
               state_d  = ST_IDLE;
            end
            if (bus.start && !bus.stop) begin
               if (start_val != '0) begin
                  state_d      = ST_RUN;
                  cnt_load     = 1'b1;
                  cnt_load_val = start_val;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
      endcase
   end

   // state, reload value and registered status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         reload_q <= '0;
         tc_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         reload_q <= reload_d;
         tc_q     <= tc_d;
         busy_q   <= (state_d == ST_RUN);
         done_q   <= (state_d == ST_DONE);
      end
   end

   assign bus.count = cnt;
   assign bus.tc    = tc_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - scoreboard bench for countdown_timer
module tb_countdown_timer;

   typedef struct {
      logic [5:0] count;
      logic       tc;
      logic       busy;
      logic       done;
   } exp_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   int   cyc;
   int   t0;
   exp_t sb[$];
   int   tc_log[$];

   // reference model state: 0 idle, 1 run, 2 done
   int         m_state;
   logic [5:0] m_count;
   logic [5:0] m_reload;

   countdown_timer_if #(.WIDTH(6)) ifc ();

   countdown_timer #(.WIDTH(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_state  = 0;
      m_count  = 6'd0;
      m_reload = 6'd0;
   endtask

   function automatic exp_t model_step(input logic ld, input logic [5:0] lv,
                                       input logic st, input logic sp, input logic ar);
      exp_t       e;
      logic [5:0] sv;
      logic [5:0] old_reload;
      e.tc = 1'b0;
      old_reload = m_reload;
      if (m_state == 1) begin
         if (ld) m_reload = lv;
         if (sp) begin
            m_state = 0;
         end else if (m_count == 6'd1) begin
            e.tc = 1'b1;
            if (ar && old_reload != 6'd0) begin
               m_count = old_reload;
            end else begin
               m_count = 6'd0;
               m_state = 2;
            end
         end else begin
            m_count = m_count - 6'd1;
         end
      end else begin
         sv = ld ? lv : ((m_count != 6'd0) ? m_count : m_reload);
         if (ld) begin
            m_reload = lv;
            m_count  = lv;
            m_state  = 0;
         end
         if (st && !sp) begin
            if (sv != 6'd0) begin
               m_state = 1;
               m_count = sv;
            end else begin
               m_state = 0;
            end
         end
      end
      e.count = m_count;
      e.busy  = (m_state == 1);
      e.done  = (m_state == 2);
      return e;
   endfunction

   task automatic step(input logic ld, input logic [5:0] lv, input logic st,
                       input logic sp, input logic ar);
      exp_t e;
      ifc.load        = ld;
      ifc.load_val    = lv;
      ifc.start       = st;
      ifc.stop        = sp;
      ifc.auto_reload = ar;
      sb.push_back(model_step(ld, lv, st, sp, ar));
      @(posedge clk);
      #1;
      cyc++;
      e = sb.pop_front();
      check("count", 32'(ifc.count), 32'(e.count));
      check("tc",    32'(ifc.tc),    32'(e.tc));
      check("busy",  32'(ifc.busy),  32'(e.busy));
      check("done",  32'(ifc.done),  32'(e.done));
      if (ifc.tc === 1'b1) tc_log.push_back(cyc);
   endtask

   task automatic idle(input int n, input logic ar);
      for (int i = 0; i < n; i++) step(1'b0, 6'd0, 1'b0, 1'b0, ar);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      cyc   = 0;
      ifc.load        = 1'b0;
      ifc.load_val    = 6'd0;
      ifc.start       = 1'b0;
      ifc.stop        = 1'b0;
      ifc.auto_reload = 1'b0;
      model_reset();
      rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst_count", 32'(ifc.count), 32'd0);
      check("rst_tc",    32'(ifc.tc),    32'd0);
      check("rst_busy",  32'(ifc.busy),  32'd0);
      check("rst_done",  32'(ifc.done),  32'd0);
      rst_n = 1'b1;

      // 1: one-shot of 5, done sticky afterwards
      step(1'b1, 6'd5, 1'b1, 1'b0, 1'b0);
      idle(8, 1'b0);

      // 2: periodic of 3
      step(1'b1, 6'd3, 1'b1, 1'b0, 1'b1);
      idle(10, 1'b1);
      step(1'b0, 6'd0, 1'b0, 1'b1, 1'b1);

      // 3: stop at 4, hold, resume
      step(1'b1, 6'd10, 1'b1, 1'b0, 1'b0);
      idle(6, 1'b0);
      check("pre_stop_count", 32'(ifc.count), 32'd4);
      step(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
      idle(3, 1'b0);
      tc_log.delete();
      step(1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
      idle(6, 1'b0);
      check("resume_tc_count", 32'(tc_log.size()), 32'd1);

      // 4: zero start stays idle; 63 one-shot
      step(1'b1, 6'd0, 1'b1, 1'b0, 1'b0);
      idle(2, 1'b0);
      tc_log.delete();
      step(1'b1, 6'd63, 1'b1, 1'b0, 1'b0);
      t0 = cyc;
      idle(66, 1'b0);
      check("max_tc_count", 32'(tc_log.size()), 32'd1);
      if (tc_log.size() > 0) check("max_tc_delay", 32'(tc_log[0] - t0), 32'd63);

      // 5: async reset mid-run at 40, then start+stop from idle
      step(1'b1, 6'd63, 1'b1, 1'b0, 1'b0);
      idle(23, 1'b0);
      check("pre_rst_count", 32'(ifc.count), 32'd40);
      rst_n = 1'b0;
      #1;
      check("async_rst_count", 32'(ifc.count), 32'd0);
      check("async_rst_busy",  32'(ifc.busy),  32'd0);
      check("async_rst_done",  32'(ifc.done),  32'd0);
      model_reset();
      #1;
      rst_n = 1'b1;
      step(1'b1, 6'd5, 1'b0, 1'b0, 1'b0);
      step(1'b0, 6'd0, 1'b1, 1'b1, 1'b0);
      idle(2, 1'b0);

      // 6: period 4 retargeted to 2 while running
      tc_log.delete();
      step(1'b1, 6'd4, 1'b1, 1'b0, 1'b1);
      t0 = cyc;
      step(1'b1, 6'd2, 1'b0, 1'b0, 1'b1);
      idle(9, 1'b1);
      step(1'b0, 6'd0, 1'b0, 1'b1, 1'b1);
      check("retarget_tc_n", 32'(tc_log.size() >= 3), 32'd1);
      if (tc_log.size() >= 3) begin
         check("retarget_first", 32'(tc_log[0] - t0), 32'd4);
         check("retarget_gap1", 32'(tc_log[1] - tc_log[0]), 32'd2);
         check("retarget_gap2", 32'(tc_log[2] - tc_log[1]), 32'd2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
